adam_aes_cbc_driver: RTL and testbench
======================================

Name: adam_aes_cbc_driver

Overview:
- Command initiator for the AES core's start/ready/result_valid interface.
- Accepts a valid/ready stream of 128-bit blocks and issues one core operation per block.
- Applies ECB or CBC chaining in the driver: XORs with a chain register, updates the chain, and emits results on an output valid/ready stream.
- Sits between a DMA/stream front-end and the AES core; the key is routed to the core separately and is not handled here.

Parameters:
- none

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- cfg_cbc  in  1  1 = CBC chaining, 0 = ECB; sampled at input accept
- cfg_encdec  in  1  1 = encrypt, 0 = decrypt; sampled at input accept
- iv  in  128  initialisation vector
- iv_load  in  1  pulse: load iv into chain register (IDLE only)
- in_valid / in_ready  in / out  1 / 1  input stream handshake
- in_data  in  128  input block (plaintext on encrypt, ciphertext on decrypt)
- in_last  in  1  last block of message; forwarded to out_last
- out_valid / out_ready  out / in  1 / 1  output stream handshake
- out_data  out  128  result block
- out_last  out  1  forwarded last flag
- busy  out  1  state != IDLE
- core_start  out  1  one-cycle start pulse to core
- core_encdec  out  1  registered direction to core
- core_block  out  128  registered block to core; held stable START..result
- core_ready  in  1  core ready
- core_result_valid  in  1  core result valid
- core_result  in  128  core result

Behaviour:
- Reset values: every output and register is 0, state IDLE, chain = 0. That includes in_ready, core_start, out_valid, busy and chain.
- Reset mid-operation: abort, return to IDLE, no output. The core shares reset_n.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - in_ready = !iv_load.
  - iv_load: chain <= iv. It takes priority over in_valid in the same cycle.
  - Accept (in_valid && in_ready): latch cfg_cbc, cfg_encdec and in_last; save in_data to din; go to ISSUE.
  - core_block <= (cfg_cbc && cfg_encdec) ? in_data ^ chain : in_data.
- ISSUE:
  - If core_ready = 1: core_start = 1 for exactly this cycle, then go to WAIT.
  - Otherwise stay in ISSUE with core_start = 0.
- WAIT:
  - Complete when core_ready && core_result_valid, both high in the same cycle. This is safe from the first WAIT cycle because the core clears both on the edge that accepts start.
  - Encrypt: out_data <= core_result.
  - Decrypt: out_data <= cbc ? core_result ^ chain : core_result.
  - If cbc: chain <= (encrypt ? core_result : din). ECB leaves chain unchanged.
  - Go to OUT.
- OUT:
  - out_valid = 1; out_data and out_last are held until out_ready.
  - On handshake go to IDLE.
  - out_ready low holds OUT indefinitely; no new input is accepted.
- Timing:
  - in_ready is low in every state except IDLE, so one block is in flight at most.
  - Best case: accept at cycle N, core_start at N+1, out_valid the cycle after the core completes.
- Chaining across messages:
  - in_last has no effect on chain; the next message reuses chain unless iv_load is pulsed.
  - iv_load is ignored outside IDLE.
- Mode changes: cfg_* may change freely and take effect only at the next accept. Switching encrypt/decrypt mid-message is legal and uses the current chain.
- No error conditions exist; core_result_valid without core_ready is ignored.

Optional Feature:
- Macro: ADAM_AES_CBC_DRV_CNT_EN
- Defined:
  - Adds output port blk_count (32 bits, reset 0).
  - Increments on each out_valid && out_ready; wraps 0xFFFFFFFF -> 0.
  - Cleared by an accepted iv_load; a clear in the same cycle as a handshake is impossible because iv_load is only accepted in IDLE.
- Undefined: port and counter absent; the block is otherwise identical.

Test Plan:
- ECB encrypt:
  - Stimulus: core key 000102030405060708090a0b0c0d0e0f (128-bit), in 00112233445566778899aabbccddeeff.
  - Response: out 69c4e0d86a7b0430d8cdb78070b4c55a; one core_start pulse; chain stays 0.
- CBC encrypt:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102…0f loaded, P1 6bc1bee22e409f96e93d7e117393172a, P2 ae2d8a571e03ac9c9eb76fac45af8e51 (last).
  - Response: out 7649abac8119b246cee98e9b12e9197d, then 5086cb9b507219ee95db113a917678b2 with out_last = 1.
- CBC decrypt: the two ciphertexts above with the same iv -> P1, P2 recovered exactly; chain ends at 5086cb9b….
- Backpressure:
  - Stimulus: hold out_ready = 0 for 20 cycles after out_valid.
  - Response: out_data stable, in_ready = 0, no core_start; a single handshake on release.
- Priority, abort and counter:
  - iv_load together with in_valid in IDLE -> in_ready = 0 that cycle, block accepted the next cycle using the new iv.
  - reset_n low during WAIT -> all outputs 0, IDLE, no out_valid after release.
  - With ADAM_AES_CBC_DRV_CNT_EN: blk_count = 2 after the CBC test, 0 after iv_load.

Source files
------------

// File: rtl/adam_aes_cbc_driver.sv
// adam_aes_cbc_driver
// Command initiator for the AES core. Takes one 128-bit block at a time from
// a valid/ready stream, applies ECB or CBC chaining around a single core
// operation, and returns the result on an output valid/ready stream.
// Optional build macro ADAM_AES_CBC_DRV_CNT_EN adds a 32-bit blk_count output
// that counts completed output handshakes and clears on an accepted iv_load.
//
// state | meaning
// IDLE  | waiting for an input block or an iv_load
// ISSUE | core_block set up, waiting for core_ready to pulse core_start
// WAIT  | core running, waiting for core_ready && core_result_valid
// OUT   | result presented, waiting for out_ready
`timescale 1ns/1ps
module adam_aes_cbc_driver (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cfg_cbc,
  input  logic         cfg_encdec,
  input  logic [127:0] iv,
  input  logic         iv_load,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         core_start,
  output logic         core_encdec,
  output logic [127:0] core_block,
  input  logic         core_ready,
  input  logic         core_result_valid,
  input  logic [127:0] core_result
`ifdef ADAM_AES_CBC_DRV_CNT_EN
  ,
  output logic [31:0]  blk_count
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  logic [1:0]   state;
  logic [127:0] chain;
  logic [127:0] din;
  logic         cbc_q;
  logic         accept;
  logic         done;
  logic         iv_take;

  // in_ready is gated by reset_n so it reads 0 while reset is held.
  assign in_ready    = reset_n && (state == ST_IDLE) && !iv_load;
  assign accept      = in_valid && in_ready;
  assign iv_take     = (state == ST_IDLE) && iv_load;
  assign core_start  = (state == ST_ISSUE) && core_ready;
  assign done        = (state == ST_WAIT) && core_ready && core_result_valid;
  assign out_valid   = (state == ST_OUT);
  assign busy        = (state != ST_IDLE);

  // Sequencing: one block in flight, IDLE -> ISSUE -> WAIT -> OUT -> IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept)     state <= ST_ISSUE;
        ST_ISSUE: if (core_ready) state <= ST_WAIT;
        ST_WAIT:  if (done)       state <= ST_OUT;
        ST_OUT:   if (out_ready)  state <= ST_IDLE;
        default:                  state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: latch the block and mode at accept, apply chaining around the core.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain       <= '0;
      din         <= '0;
      cbc_q       <= 1'b0;
      core_encdec <= 1'b0;
      core_block  <= '0;
      out_data    <= '0;
      out_last    <= 1'b0;
    end else begin
      if (iv_take) begin
        chain <= iv;
      end
      if (accept) begin
        cbc_q       <= cfg_cbc;
        core_encdec <= cfg_encdec;
        out_last    <= in_last;
        din         <= in_data;
        core_block  <= (cfg_cbc && cfg_encdec) ? (in_data ^ chain) : in_data;
      end
      if (done) begin
        if (core_encdec) begin
          out_data <= core_result;
        end else begin
          out_data <= cbc_q ? (core_result ^ chain) : core_result;
        end
        // Chain follows the ciphertext: core output on encrypt, input on decrypt.
        if (cbc_q) begin
          chain <= core_encdec ? core_result : din;
        end
      end
    end
  end

`ifdef ADAM_AES_CBC_DRV_CNT_EN
  // Output block counter; iv_load restarts it for a new message sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_count <= '0;
    end else if (iv_take) begin
      blk_count <= '0;
    end else if (out_valid && out_ready) begin
      blk_count <= blk_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adam_aes_cbc_driver.sv
`timescale 1ns/1ps
module tb_adam_aes_cbc_driver;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cfg_cbc, cfg_encdec, iv_load, in_valid, in_last;
  logic [127:0] iv, in_data;
  logic         in_ready, out_valid, out_ready, out_last, busy;
  logic [127:0] out_data, core_block, core_result;
  logic         core_start, core_encdec, core_ready, core_result_valid;
`ifdef ADAM_AES_CBC_DRV_CNT_EN
  logic [31:0]  blk_count;
`endif

  always #5 clk = ~clk;

  adam_aes_cbc_driver dut (
    .clk(clk), .reset_n(reset_n), .cfg_cbc(cfg_cbc), .cfg_encdec(cfg_encdec),
    .iv(iv), .iv_load(iv_load), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .core_start(core_start), .core_encdec(core_encdec),
    .core_block(core_block), .core_ready(core_ready),
    .core_result_valid(core_result_valid), .core_result(core_result)
`ifdef ADAM_AES_CBC_DRV_CNT_EN
    , .blk_count(blk_count)
`endif
  );

  // Toy invertible block cipher standing in for AES.
  function automatic logic [127:0] toy_enc(input logic [127:0] x);
    return {x[120:0], x[127:121]} ^ KEY;
  endfunction
  function automatic logic [127:0] toy_dec(input logic [127:0] y);
    logic [127:0] t;
    t = y ^ KEY;
    return {t[6:0], t[127:7]};
  endfunction

  typedef struct {
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t         q[$];
  logic [127:0] m_chain = '0;
  logic [31:0]  m_cnt = '0;
  int           hs_count = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  int           or_mode = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  // Behavioural core: random start latency, random ready stalls while idle,
  // spurious result_valid (with ready low) while busy.
  logic         core_busy;
  int           core_lat;
  logic [127:0] core_pend;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready <= 1'b0; core_result_valid <= 1'b0; core_result <= '0;
      core_busy <= 1'b0; core_lat <= 0; core_pend <= '0;
    end else if (core_busy) begin
      if (core_lat == 0) begin
        core_ready <= 1'b1; core_result_valid <= 1'b1;
        core_result <= core_pend; core_busy <= 1'b0;
      end else begin
        core_lat <= core_lat - 1;
        core_result_valid <= ($urandom_range(0, 3) == 0);
        core_result <= {$urandom, $urandom, $urandom, $urandom};
      end
    end else if (core_start && core_ready) begin
      core_ready <= 1'b0; core_result_valid <= 1'b0;
      core_pend <= core_encdec ? toy_enc(core_block) : toy_dec(core_block);
      core_lat <= $urandom_range(1, 5);
      core_busy <= 1'b1;
    end else begin
      core_result_valid <= 1'b0;
      core_ready <= ($urandom_range(0, 3) != 0);
    end
  end

  // out_ready: 0 random, 1 forced low, 2 forced high.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        1:       out_ready = 1'b0;
        2:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      m_cnt = '0;
    end else begin
      if (iv_load && !busy) m_cnt = '0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got %h expected none", out_data);
        end else begin
          e = q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", {127'd0, out_last}, {127'd0, e.last});
`ifdef ADAM_AES_CBC_DRV_CNT_EN
          chk("blk_count", {96'd0, blk_count}, {96'd0, m_cnt});
`endif
        end
        m_cnt = m_cnt + 32'd1;
        hs_count++;
      end
    end
  end

  // Reference for one accepted block, computed from the chaining rules.
  task automatic model_accept();
    exp_t e;
    logic [127:0] r;
    if (cfg_encdec) begin
      r = toy_enc(cfg_cbc ? (in_data ^ m_chain) : in_data);
      if (cfg_cbc) m_chain = r;
    end else begin
      r = toy_dec(in_data);
      if (cfg_cbc) begin
        r = r ^ m_chain;
        m_chain = in_data;
      end
    end
    e.data = r;
    e.last = in_last;
    q.push_back(e);
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_cbc = 1'($urandom);
        cfg_encdec = 1'($urandom);
        in_data = {$urandom, $urandom, $urandom, $urandom};
        return;
      end
    end
    fail_timeout("accept");
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input logic cbc, input logic enc, input logic last);
    @(posedge clk);
    #1;
    in_data = d; cfg_cbc = cbc; cfg_encdec = enc; in_last = last; in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    fail_timeout("idle");
  endtask

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) return;
    end
    fail_timeout("drain");
  endtask

  task automatic load_iv(input logic [127:0] v);
    wait_idle();
    @(posedge clk);
    #1;
    iv = v; iv_load = 1'b1;
    m_chain = v;
    @(posedge clk);
    #1;
    iv_load = 1'b0;
  endtask

  // Called right after an accept: DUT is busy, so this iv_load must be ignored.
  task automatic pulse_iv_busy();
    iv = {$urandom, $urandom, $urandom, $urandom};
    iv_load = 1'b1;
    @(posedge clk);
    #1;
    iv_load = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, {127'd0, in_ready}, 128'd0);
    chk({tag, "_out_valid"}, {127'd0, out_valid}, 128'd0);
    chk({tag, "_busy"}, {127'd0, busy}, 128'd0);
    chk({tag, "_core_start"}, {127'd0, core_start}, 128'd0);
    chk({tag, "_core_encdec"}, {127'd0, core_encdec}, 128'd0);
    chk({tag, "_out_last"}, {127'd0, out_last}, 128'd0);
    chk({tag, "_out_data"}, out_data, 128'd0);
    chk({tag, "_core_block"}, core_block, 128'd0);
`ifdef ADAM_AES_CBC_DRV_CNT_EN
    chk({tag, "_blk_count"}, {96'd0, blk_count}, 128'd0);
`endif
  endtask

  initial begin
    logic [127:0] c1, c2, newiv;
    exp_t e;
    int h0;
    bool_wait: begin end
    reset_n = 1'b0;
    cfg_cbc = 1'b0; cfg_encdec = 1'b0; iv = '0; iv_load = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // ECB encrypt, chain stays at its reset value of 0.
    send(128'h00112233445566778899aabbccddeeff, 1'b0, 1'b1, 1'b1);
    drain();
    // CBC encrypt after iv_load.
    load_iv(IV0);
    c1 = toy_enc(P1 ^ IV0);
    c2 = toy_enc(P2 ^ c1);
    send(P1, 1'b1, 1'b1, 1'b0);
    send(P2, 1'b1, 1'b1, 1'b1);
    drain();
`ifdef ADAM_AES_CBC_DRV_CNT_EN
    chk("blk_count_after_cbc", {96'd0, blk_count}, 128'd2);
`endif
    load_iv(IV0);
`ifdef ADAM_AES_CBC_DRV_CNT_EN
    @(negedge clk);
    chk("blk_count_after_iv", {96'd0, blk_count}, 128'd0);
`endif
    // CBC decrypt recovers P1, P2; the following encrypt proves chain == c2.
    send(c1, 1'b1, 1'b0, 1'b0);
    send(c2, 1'b1, 1'b0, 1'b1);
    drain();
    send(128'h0f0e0d0c0b0a09080706050403020100, 1'b1, 1'b1, 1'b1);
    drain();

    // Backpressure: output held for 20 cycles while new input is offered.
    or_mode = 1;
    h0 = hs_count;
    send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0);
    begin
      int k;
      for (k = 0; k < 200; k++) begin
        @(negedge clk);
        if (out_valid) break;
      end
      if (k == 200) fail_timeout("bp_out_valid");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1; cfg_cbc = 1'b1; cfg_encdec = 1'b1;
    e = q[0];
    repeat (20) begin
      @(negedge clk);
      chk("bp_out_data", out_data, e.data);
      chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
      chk("bp_core_start", {127'd0, core_start}, 128'd0);
    end
    in_valid = 1'b0;
    or_mode = 2;
    drain();
    chk("bp_handshakes", 128'(hs_count - h0), 128'd1);
    or_mode = 0;

    // iv_load with in_valid in IDLE: iv wins, block accepted next cycle with new iv.
    wait_idle();
    newiv = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    iv = newiv; iv_load = 1'b1;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    cfg_cbc = 1'b1; cfg_encdec = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("prio_in_ready", {127'd0, in_ready}, 128'd0);
    m_chain = newiv;
    @(posedge clk);
    #1;
    iv_load = 1'b0;
    wait_accept();
    drain();

    // Random traffic with mode switches and ignored iv_load pulses.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) load_iv({$urandom, $urandom, $urandom, $urandom});
      send({$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 5) == 0) pulse_iv_busy();
      if ($urandom_range(0, 2) == 0) drain();
    end
    drain();

    // Abort: reset during WAIT produces no output.
    send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b0);
    begin
      int k;
      for (k = 0; k < 200; k++) begin
        @(negedge clk);
        if (core_start) break;
      end
      if (k == 200) fail_timeout("abort_core_start");
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk_all_zero("abort");
    q.delete();
    m_chain = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      chk("abort_no_out_valid", {127'd0, out_valid}, 128'd0);
    end
    // Chain restarts from 0 after reset.
    send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
